// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: EX operand forward selects,
// load-use stall, multi-cycle EX op sequencing and a saturating stall-cycle counter.
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_multi,
  input  logic              flush,
  output logic [1:0]        forward_a_sel,
  output logic [1:0]        forward_b_sel,
  output logic              stall_if,
  output logic              hold_ex,
  output logic              bubble_ex,
  output logic              bubble_mem,
  output logic              mc_start,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [3:0] MC_LAST = 4'(MC_LAT - 1);

  typedef enum logic {IDLE, MC_BUSY} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;

  logic              ex_valid_reg, ex_we_reg, ex_load_reg, ex_multi_reg;
  logic              ex_rs1_used_reg, ex_rs2_used_reg;
  logic [REG_AW-1:0] ex_rd_reg, ex_rs1_reg, ex_rs2_reg;
  logic              mem_valid_reg, mem_we_reg;
  logic [REG_AW-1:0] mem_rd_reg;
  logic              wb_valid_reg, wb_we_reg;
  logic [REG_AW-1:0] wb_rd_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic              ld_stall;
  logic              enter_multi;

  // Forwarding for both EX source operands; index 0 of each array is rs1, index 1 is rs2.
  logic [REG_AW-1:0] src_idx  [2];
  logic              src_used [2];
  logic [1:0]        fwd_sel  [2];

  assign src_idx[0]  = ex_rs1_reg;
  assign src_idx[1]  = ex_rs2_reg;
  assign src_used[0] = ex_rs1_used_reg;
  assign src_used[1] = ex_rs2_used_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic hit_mem, hit_wb;
    assign hit_mem = ex_valid_reg & src_used[gi] & mem_valid_reg & mem_we_reg &
                     (mem_rd_reg != '0) & (src_idx[gi] == mem_rd_reg);
    assign hit_wb  = ex_valid_reg & src_used[gi] & wb_valid_reg & wb_we_reg &
                     (wb_rd_reg != '0) & (src_idx[gi] == wb_rd_reg);
    assign fwd_sel[gi] = hit_mem ? 2'b10 : (hit_wb ? 2'b01 : 2'b00);
  end

  assign forward_a_sel = fwd_sel[0];
  assign forward_b_sel = fwd_sel[1];

  assign hold_ex  = (state_reg == MC_BUSY) & ex_valid_reg & ex_multi_reg & (cnt_reg != MC_LAST);
  assign mc_start = (state_reg == MC_BUSY) & (cnt_reg == 4'd0);

  assign ld_stall = ex_valid_reg & ex_load_reg & ex_we_reg & (ex_rd_reg != '0) & id_valid &
                    ((id_rs1_used & (id_rs1 == ex_rd_reg)) | (id_rs2_used & (id_rs2 == ex_rd_reg))) &
                    ~hold_ex;

  // flush is a raw input, so mask it while reset is asserted to keep every control low.
  assign bubble_ex  = (ld_stall | flush) & ~hold_ex & rst_n;
  assign stall_if   = ld_stall | hold_ex;
  assign bubble_mem = hold_ex;
  assign stall_cnt  = stall_cnt_reg;

  // A multi op is considered started on the edge that loads it into EX.
  assign enter_multi = ~hold_ex & ~bubble_ex & id_valid & id_is_multi;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = 4'd0;
        if (enter_multi) state_next = MC_BUSY;
      end
      MC_BUSY: begin
        if (cnt_reg == MC_LAST) begin
          cnt_next   = 4'd0;
          state_next = enter_multi ? MC_BUSY : IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      ex_valid_reg    <= 1'b0;
      ex_we_reg       <= 1'b0;
      ex_load_reg     <= 1'b0;
      ex_multi_reg    <= 1'b0;
      ex_rs1_used_reg <= 1'b0;
      ex_rs2_used_reg <= 1'b0;
      ex_rd_reg       <= '0;
      ex_rs1_reg      <= '0;
      ex_rs2_reg      <= '0;
      mem_valid_reg   <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_rd_reg      <= '0;
      wb_valid_reg    <= 1'b0;
      wb_we_reg       <= 1'b0;
      wb_rd_reg       <= '0;
      stall_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      wb_valid_reg  <= mem_valid_reg;
      wb_we_reg     <= mem_we_reg;
      wb_rd_reg     <= mem_rd_reg;
      mem_valid_reg <= ex_valid_reg & ~hold_ex;
      mem_we_reg    <= ex_we_reg;
      mem_rd_reg    <= ex_rd_reg;
      if (!hold_ex) begin
        ex_valid_reg    <= id_valid & ~bubble_ex;
        ex_we_reg       <= id_we;
        ex_load_reg     <= id_is_load;
        ex_multi_reg    <= id_is_multi;
        ex_rs1_used_reg <= id_rs1_used;
        ex_rs2_used_reg <= id_rs2_used;
        ex_rd_reg       <= id_rd;
        ex_rs1_reg      <= id_rs1;
        ex_rs2_reg      <= id_rs2;
      end
      if (stall_if && (stall_cnt_reg != {CNT_W{1'b1}})) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl; a second instance with a 4-bit
// stall counter shares the stimulus to exercise counter saturation.
module tb_hazard_forward_ctrl;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       we;
    logic       ld;
    logic       mul;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, id_is_multi, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] forward_a_sel, forward_b_sel, sat_fa, sat_fb;
  logic       stall_if, hold_ex, bubble_ex, bubble_mem, mc_start;
  logic       sat_stall_if, sat_hold_ex, sat_bubble_ex, sat_bubble_mem, sat_mc_start;
  logic [15:0] stall_cnt;
  logic [3:0]  sat_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int holds, starts, stalls;
  instr_t q[$];

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_multi(id_is_multi), .flush(flush),
    .forward_a_sel(forward_a_sel), .forward_b_sel(forward_b_sel), .stall_if(stall_if),
    .hold_ex(hold_ex), .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .mc_start(mc_start),
    .stall_cnt(stall_cnt)
  );

  hazard_forward_ctrl #(.REG_AW(5), .MC_LAT(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_multi(id_is_multi), .flush(flush),
    .forward_a_sel(sat_fa), .forward_b_sel(sat_fb), .stall_if(sat_stall_if),
    .hold_ex(sat_hold_ex), .bubble_ex(sat_bubble_ex), .bubble_mem(sat_bubble_mem),
    .mc_start(sat_mc_start), .stall_cnt(sat_cnt)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic we,
                                input logic ld, input logic mul);
    instr_t t;
    t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.we = we; t.ld = ld; t.mul = mul;
    return t;
  endfunction

  task automatic present(input instr_t t);
    id_valid = 1'b1; id_rd = t.rd; id_rs1 = t.rs1; id_rs2 = t.rs2;
    id_rs1_used = t.u1; id_rs2_used = t.u2; id_we = t.we; id_is_load = t.ld; id_is_multi = t.mul;
  endtask

  task automatic idle_id();
    id_valid = 1'b0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_we = 1'b0; id_is_load = 1'b0; id_is_multi = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_id();
    for (int i = 0; i < 3; i++) tick();
  endtask

  // Feeds the queue into ID, holding the head while stall_if is high (IF/ID held).
  task automatic run(input int ncyc, output int h, output int s, output int st);
    h = 0; s = 0; st = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (q.size() > 0) present(q[0]);
      else idle_id();
      #1;
      h  += int'(hold_ex);
      s  += int'(mc_start);
      st += int'(stall_if);
      if (!stall_if && q.size() > 0) void'(q.pop_front());
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    idle_id();
    #2;
    check_eq("rst_fwd_a", int'(forward_a_sel), 0);
    check_eq("rst_stall_if", int'(stall_if), 0);
    check_eq("rst_mc_start", int'(mc_start), 0);
    check_eq("rst_stall_cnt", int'(stall_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;

    // EX/MEM forward: add x5; add x6,x5,x1
    present(mk(5'd5, 5'd1, 5'd2, 1, 1, 1, 0, 0)); tick();
    present(mk(5'd6, 5'd5, 5'd1, 1, 1, 1, 0, 0)); #1;
    check_eq("t1_first_fwd_a", int'(forward_a_sel), 0);
    tick();
    idle_id(); #1;
    check_eq("t1_mem_fwd_a", int'(forward_a_sel), 2);
    check_eq("t1_mem_fwd_b", int'(forward_b_sel), 0);
    drain();

    // MEM/WB forward with an intervening writer of x7
    present(mk(5'd5, 5'd1, 5'd2, 1, 1, 1, 0, 0)); tick();
    present(mk(5'd7, 5'd1, 5'd2, 1, 1, 1, 0, 0)); tick();
    present(mk(5'd8, 5'd5, 5'd3, 1, 1, 1, 0, 0)); tick();
    idle_id(); #1;
    check_eq("t2_wb_fwd_a", int'(forward_a_sel), 1);
    check_eq("t2_wb_fwd_b", int'(forward_b_sel), 0);
    drain();

    // MEM and WB both write x5: MEM wins
    present(mk(5'd5, 5'd1, 5'd2, 1, 1, 1, 0, 0)); tick();
    present(mk(5'd5, 5'd3, 5'd4, 1, 1, 1, 0, 0)); tick();
    present(mk(5'd9, 5'd5, 5'd5, 1, 1, 1, 0, 0)); tick();
    idle_id(); #1;
    check_eq("t2_prio_fwd_a", int'(forward_a_sel), 2);
    check_eq("t2_prio_fwd_b", int'(forward_b_sel), 2);
    drain();

    // Load-use: lw x5; add x6,x1,x5
    present(mk(5'd5, 5'd1, 5'd0, 1, 0, 1, 1, 0)); tick();
    present(mk(5'd6, 5'd1, 5'd5, 1, 1, 1, 0, 0)); #1;
    check_eq("t3_ld_stall_if", int'(stall_if), 1);
    check_eq("t3_ld_bubble_ex", int'(bubble_ex), 1);
    check_eq("t3_ld_hold_ex", int'(hold_ex), 0);
    tick(); #1;
    check_eq("t3_ld_stall_once", int'(stall_if), 0);
    check_eq("t3_ld_bubble_once", int'(bubble_ex), 0);
    tick();
    idle_id(); #1;
    check_eq("t3_ld_fwd_b", int'(forward_b_sel), 1);
    check_eq("t3_ld_fwd_a", int'(forward_a_sel), 0);
    check_eq("t3_ld_cnt", int'(stall_cnt), 1);
    drain();

    // Load to x0 never stalls or forwards
    present(mk(5'd0, 5'd1, 5'd0, 1, 0, 1, 1, 0)); tick();
    present(mk(5'd6, 5'd1, 5'd0, 1, 1, 1, 0, 0)); #1;
    check_eq("t3_x0_stall_if", int'(stall_if), 0);
    check_eq("t3_x0_bubble_ex", int'(bubble_ex), 0);
    tick();
    idle_id(); #1;
    check_eq("t3_x0_fwd_b", int'(forward_b_sel), 0);
    drain();

    // Single multi op, MC_LAT = 4
    present(mk(5'd10, 5'd3, 5'd4, 1, 1, 1, 0, 1)); tick();
    present(mk(5'd11, 5'd10, 5'd1, 1, 1, 1, 0, 0)); #1;
    check_eq("t4_c0_mc_start", int'(mc_start), 1);
    check_eq("t4_c0_hold_ex", int'(hold_ex), 1);
    check_eq("t4_c0_stall_if", int'(stall_if), 1);
    check_eq("t4_c0_bubble_mem", int'(bubble_mem), 1);
    check_eq("t4_c0_bubble_ex", int'(bubble_ex), 0);
    tick(); #1;
    check_eq("t4_c1_mc_start", int'(mc_start), 0);
    check_eq("t4_c1_hold_ex", int'(hold_ex), 1);
    tick(); #1;
    check_eq("t4_c2_hold_ex", int'(hold_ex), 1);
    tick(); #1;
    check_eq("t4_c3_hold_ex", int'(hold_ex), 0);
    check_eq("t4_c3_stall_if", int'(stall_if), 0);
    check_eq("t4_c3_bubble_mem", int'(bubble_mem), 0);
    tick();
    idle_id(); #1;
    check_eq("t4_dep_fwd_a", int'(forward_a_sel), 2);
    check_eq("t4_cnt", int'(stall_cnt), 4);
    drain();

    // Back-to-back multi ops
    q.push_back(mk(5'd12, 5'd1, 5'd2, 1, 1, 1, 0, 1));
    q.push_back(mk(5'd13, 5'd1, 5'd2, 1, 1, 1, 0, 1));
    run(12, holds, starts, stalls);
    check_eq("t4_b2b_holds", holds, 6);
    check_eq("t4_b2b_starts", starts, 2);
    check_eq("t4_b2b_cnt", int'(stall_cnt), 10);
    check_eq("t4_b2b_sat_cnt", int'(sat_cnt), 10);

    // Flush kills the ID instruction
    present(mk(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0)); tick();
    present(mk(5'd6, 5'd1, 5'd1, 1, 1, 1, 0, 0)); flush = 1'b1; #1;
    check_eq("t5_flush_bubble_ex", int'(bubble_ex), 1);
    check_eq("t5_flush_stall_if", int'(stall_if), 0);
    tick();
    flush = 1'b0; idle_id(); #1;
    check_eq("t5_flush_fwd_a", int'(forward_a_sel), 0);
    check_eq("t5_flush_fwd_b", int'(forward_b_sel), 0);
    drain();

    // Reset during cycle 2 of a multi op
    present(mk(5'd14, 5'd1, 5'd2, 1, 1, 1, 0, 1)); tick();
    idle_id(); #1;
    check_eq("t6_mc_start", int'(mc_start), 1);
    tick();
    rst_n = 1'b0; #1;
    check_eq("t6_rst_hold_ex", int'(hold_ex), 0);
    check_eq("t6_rst_stall_if", int'(stall_if), 0);
    check_eq("t6_rst_bubble_mem", int'(bubble_mem), 0);
    check_eq("t6_rst_mc_start", int'(mc_start), 0);
    check_eq("t6_rst_cnt", int'(stall_cnt), 0);
    check_eq("t6_rst_sat_cnt", int'(sat_cnt), 0);
    tick();
    rst_n = 1'b1; #1;
    check_eq("t6_post_hold_ex", int'(hold_ex), 0);
    check_eq("t6_post_mc_start", int'(mc_start), 0);
    tick();
    q.push_back(mk(5'd15, 5'd1, 5'd2, 1, 1, 1, 0, 1));
    run(8, holds, starts, stalls);
    check_eq("t6_restart_holds", holds, 3);
    check_eq("t6_restart_starts", starts, 1);
    check_eq("t6_restart_cnt", int'(stall_cnt), 3);

    // Saturation: 7 multi ops = 21 more stall cycles
    for (int i = 0; i < 7; i++) q.push_back(mk(5'(16 + i), 5'd1, 5'd2, 1, 1, 1, 0, 1));
    run(40, holds, starts, stalls);
    check_eq("t7_stalls", stalls, 21);
    check_eq("t7_cnt16", int'(stall_cnt), 24);
    check_eq("t7_sat_cnt4", int'(sat_cnt), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
